// File: rtl/bus_src_arbiter.sv
// Round-robin arbiter for the 16-bit internal source bus. It registers a one-hot grant
// and the matching 16:1 mux select, with a bounded hold time while the bus is contended.
module bus_src_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter logic [3:0]  SRC0     = 4'd0,
    parameter logic [3:0]  SRC1     = 4'd1,
    parameter logic [3:0]  SRC2     = 4'd2,
    parameter logic [3:0]  SRC3     = 4'd3,
    parameter logic [3:0]  IDLE_SRC = 4'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [3:0] sel,
    output logic       busy,
    output logic [3:0] hold_cnt
);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [3:0] grant_nxt;
    logic [3:0] sel_nxt;
    logic [3:0] hold_nxt;
    logic [1:0] cand;
    logic       cand_found;
    logic       others_waiting;
    logic       keep;

    function automatic logic [3:0] src_of(input logic [1:0] idx);
        case (idx)
            2'd0:    src_of = SRC0;
            2'd1:    src_of = SRC1;
            2'd2:    src_of = SRC2;
            default: src_of = SRC3;
        endcase
    endfunction

    // The candidate search starts just after the last owner and ends on the owner itself.
    always_comb begin
        logic [1:0] idx;
        idx        = ptr;
        cand       = ptr;
        cand_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!cand_found && req[idx]) begin
                cand       = idx;
                cand_found = 1'b1;
            end
        end
    end

    // While busy, ptr always names the current owner.
    assign others_waiting = |(req & ~grant);
    assign keep = (state == GRANTED) && req[ptr] &&
                  ((hold_cnt < HOLD_MAX) || !others_waiting);

    // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        grant_nxt = grant;
        sel_nxt   = sel;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                if (cand_found) begin
                    state_nxt = GRANTED;
                    ptr_nxt   = cand;
                    grant_nxt = 4'b0001 << cand;
                    sel_nxt   = src_of(cand);
                    hold_nxt  = 4'd1;
                end
            end
            GRANTED: begin
                if (keep) begin
                    if (hold_cnt < HOLD_MAX) begin
                        hold_nxt = hold_cnt + 4'd1;
                    end
                end else if (cand_found) begin
                    ptr_nxt   = cand;
                    grant_nxt = 4'b0001 << cand;
                    sel_nxt   = src_of(cand);
                    hold_nxt  = 4'd1;
                end else begin
                    state_nxt = IDLE;
                    grant_nxt = 4'b0000;
                    sel_nxt   = IDLE_SRC;
                    hold_nxt  = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 4'b0000;
                sel_nxt   = IDLE_SRC;
                hold_nxt  = 4'd0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd3;
            grant    <= 4'b0000;
            sel      <= IDLE_SRC;
            hold_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            grant    <= grant_nxt;
            sel      <= sel_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    assign busy = (state == GRANTED);

endmodule

// File: tb/tb_bus_src_arbiter.sv
// Self-checking bench for bus_src_arbiter: a vector table plus hand-written timeout,
// saturation and reset sequences, all checked through an expected-value queue.
module tb_bus_src_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] sel;
    logic       busy;
    logic [3:0] hold_cnt;

    int tests_run;
    int tests_failed;

    typedef struct packed {
        logic [3:0] grant;
        logic [3:0] sel;
        logic       busy;
        logic [3:0] hold;
    } out_t;

    typedef struct packed {
        logic       rst_before;
        logic [3:0] req;
        logic [3:0] grant;
        logic [3:0] sel;
        logic [3:0] hold;
    } vec_t;

    out_t  exp_q[$];
    string name_q[$];
    vec_t  vecs[$];

    bus_src_arbiter #(
        .MAX_HOLD(8),
        .SRC0(4'd0),
        .SRC1(4'd1),
        .SRC2(4'd2),
        .SRC3(4'd3),
        .IDLE_SRC(4'd15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .grant(grant),
        .sel(sel),
        .busy(busy),
        .hold_cnt(hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input out_t act, input out_t exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got grant=%b sel=%h busy=%b hold=%0d, want grant=%b sel=%h busy=%b hold=%0d",
                     name, act.grant, act.sel, act.busy, act.hold,
                     exp.grant, exp.sel, exp.busy, exp.hold);
        end
    endtask

    function automatic out_t now_out();
        now_out = '{grant: grant, sel: sel, busy: busy, hold: hold_cnt};
    endfunction

    // Drive one request pattern before the next edge and queue what must appear after it.
    task automatic drive(input logic [3:0] r, input logic [3:0] g, input logic [3:0] s,
                         input logic [3:0] h, input string name);
        @(negedge clk);
        req = r;
        exp_q.push_back('{grant: g, sel: s, busy: |g, hold: h});
        name_q.push_back(name);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        req = 4'b0000;
        rst = 1'b1;
        #1;
        check("reset_state", now_out(), '{grant: 4'b0000, sel: 4'hF, busy: 1'b0, hold: 4'd0});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        out_t  e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, now_out(), e);
            end
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        req = 4'b0000;

        // single request, then simultaneous requests, then round-robin with 2-cycle holds
        vecs.push_back('{1'b1, 4'b0010, 4'b0010, 4'd1,  4'd1});
        vecs.push_back('{1'b0, 4'b0010, 4'b0010, 4'd1,  4'd2});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, 4'hF,  4'd0});
        vecs.push_back('{1'b1, 4'b0101, 4'b0001, 4'd0,  4'd1});
        vecs.push_back('{1'b0, 4'b0100, 4'b0100, 4'd2,  4'd1});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, 4'hF,  4'd0});
        vecs.push_back('{1'b1, 4'b1111, 4'b0001, 4'd0,  4'd1});
        vecs.push_back('{1'b0, 4'b1111, 4'b0001, 4'd0,  4'd2});
        vecs.push_back('{1'b0, 4'b1110, 4'b0010, 4'd1,  4'd1});
        vecs.push_back('{1'b0, 4'b1111, 4'b0010, 4'd1,  4'd2});
        vecs.push_back('{1'b0, 4'b1101, 4'b0100, 4'd2,  4'd1});
        vecs.push_back('{1'b0, 4'b1111, 4'b0100, 4'd2,  4'd2});
        vecs.push_back('{1'b0, 4'b1011, 4'b1000, 4'd3,  4'd1});
        vecs.push_back('{1'b0, 4'b1111, 4'b1000, 4'd3,  4'd2});
        vecs.push_back('{1'b0, 4'b0111, 4'b0001, 4'd0,  4'd1});
        vecs.push_back('{1'b0, 4'b1111, 4'b0001, 4'd0,  4'd2});
        vecs.push_back('{1'b0, 4'b1110, 4'b0010, 4'd1,  4'd1});
        // a waiting requester that drops is skipped
        vecs.push_back('{1'b0, 4'b0110, 4'b0010, 4'd1,  4'd2});
        vecs.push_back('{1'b0, 4'b1000, 4'b1000, 4'd3,  4'd1});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, 4'hF,  4'd0});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) reset_dut();
            drive(vecs[i].req, vecs[i].grant, vecs[i].sel, vecs[i].hold,
                  $sformatf("vec%0d", i));
        end

        // contended timeout: 0 and 3 alternate every 8 cycles
        reset_dut();
        for (int c = 0; c < 40; c++) begin
            drive(4'b1001,
                  ((c / 8) % 2 == 1) ? 4'b1000 : 4'b0001,
                  ((c / 8) % 2 == 1) ? 4'd3 : 4'd0,
                  4'((c % 8) + 1),
                  $sformatf("timeout_c%0d", c));
        end

        // uncontended hold saturates, then a new requester takes over at once
        reset_dut();
        for (int c = 0; c < 20; c++) begin
            drive(4'b1000, 4'b1000, 4'd3, (c < 8) ? 4'(c + 1) : 4'd8,
                  $sformatf("saturate_c%0d", c));
        end
        drive(4'b1010, 4'b0010, 4'd1, 4'd1, "saturate_handover");
        drive(4'b0000, 4'b0000, 4'hF, 4'd0, "saturate_idle");

        // asynchronous reset while requester 2 owns the bus, then re-arbitration from ptr = 3
        reset_dut();
        drive(4'b0100, 4'b0100, 4'd2, 4'd1, "midrst_grant");
        drive(4'b1100, 4'b0100, 4'd2, 4'd2, "midrst_keep");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_async", now_out(), '{grant: 4'b0000, sel: 4'hF, busy: 1'b0, hold: 4'd0});
        rst = 1'b0;
        drive(4'b1100, 4'b0100, 4'd2, 4'd1, "midrst_rearb");
        drive(4'b0000, 4'b0000, 4'hF, 4'd0, "midrst_idle");

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bus_src_arbiter.md
# bus_src_arbiter

Round-robin arbiter that shares the processor's 16-bit internal source bus between four requesters. The bus is formed by the 16:1 source multiplexer. The block registers a one-hot grant and drives the multiplexer's 4-bit select with the source code of the granted requester. When the bus is idle, the select is parked on a fixed idle source. Each granted requester holds the bus until it releases it, or until a maximum hold time expires while other requesters are waiting.

## Interface
- MAX_HOLD, 8: maximum consecutive grant cycles while contended; legal range 1..15.
- SRC0, 4'd0: multiplexer source code for requester 0.
- SRC1, 4'd1: multiplexer source code for requester 1.
- SRC2, 4'd2: multiplexer source code for requester 2.
- SRC3, 4'd3: multiplexer source code for requester 3.
- IDLE_SRC, 4'd15: select code driven when no grant is active.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  level request, one bit per requester; the requester holds it high for as long as it wants the bus.
- grant  output  4  registered one-hot grant, or all zeros.
- sel  output  4  registered multiplexer select; sel[3] drives mux input i1 (MSB) and sel[0] drives i4.
- busy  output  1  high when any grant bit is high.
- hold_cnt  output  4  number of cycles the current grant has been held, including the current cycle; saturates at MAX_HOLD.

## Operation
- Internal state:
  - ptr (2 bits): index of the most recently granted requester.
  - grant, sel, busy, hold_cnt: all registered outputs.
- Search order each edge: ptr+1, ptr+2, ptr+3, ptr (all mod 4). The first requester in this order with req high is the candidate.
- Keep rule: the current grant g is kept when busy, req[g] is high, and either hold_cnt < MAX_HOLD or no other req bit is high.
  - On keep: grant, sel and ptr are unchanged; hold_cnt increments, saturating at MAX_HOLD.
- Switch rule: if the keep rule fails and any req bit is high, the candidate is granted.
  - grant = one-hot(candidate), sel = SRC[candidate], busy = 1, hold_cnt = 1, ptr = candidate.
  - On timeout the current owner is last in the search order, so it is re-granted only when it is the sole requester. In that case the keep rule applies, so this does not occur in practice.
- Idle rule: if no req bit is high, grant = 0, sel = IDLE_SRC, busy = 0, hold_cnt = 0, ptr unchanged.
- State-machine view:
  - IDLE (busy = 0) to GRANTED on any req.
  - GRANTED to GRANTED (keep or switch).
  - GRANTED to IDLE when all req bits are low.
- Handover has no dead cycle: release and the new grant take effect on the same edge.
- Reset values:
  - grant = 4'b0000, sel = IDLE_SRC, busy = 0, hold_cnt = 0.
  - ptr = 3, so requester 0 has first priority after reset.
- Reset mid-grant: all outputs return to their reset values asynchronously. Requests still pending are re-arbitrated from ptr = 3 at the first edge after rst deasserts.
- The arbiter never issues more than one grant bit. grant, sel and busy always change on the same edge.

## Timing
- Latency from request to grant: req sampled high at edge k gives grant and sel valid after edge k. This is one cycle from the cycle req was set up.
- Latency from release to regrant: req[g] sampled low at edge k means grant[g] falls after edge k, and the next candidate (if any) is granted after the same edge.
- Contended hold: the owner keeps the bus for exactly MAX_HOLD cycles. It loses the grant at the edge where hold_cnt == MAX_HOLD and another req is sampled high.
- Uncontended hold: unlimited; hold_cnt stays at MAX_HOLD.
- A requester that drops req while not granted is simply skipped; there is no request memory.
- sel is registered, so the multiplexer output is valid for the owner during the whole grant cycle.

## Test plan
- Reset:
  - Assert rst mid-cycle while grant = 4'b0100.
  - Required: immediately grant = 0, sel = 4'hF, busy = 0, hold_cnt = 0.
- Single request:
  - req = 4'b0010 from reset.
  - Required: after the next edge grant = 4'b0010, sel = 4'd1, hold_cnt = 1.
  - Drop req; after the next edge grant = 0 and sel = 4'hF.
- Simultaneous requests:
  - req = 4'b0101 from reset.
  - Required: grant = 4'b0001 first.
  - Release req[0]; on the same edge grant = 4'b0100, sel = 4'd2.
- Timeout (MAX_HOLD = 8):
  - req = 4'b1001 held continuously.
  - Required: requester 0 holds for 8 cycles, then requester 3 for 8 cycles, alternating. sel alternates 0 and 3; hold_cnt runs 1..8.
- Uncontended saturation:
  - req = 4'b1000 held for 20 cycles.
  - Required: grant stays 4'b1000 and hold_cnt saturates at 8.
  - Assert req[1]; at the next edge grant = 4'b0010.
- Round-robin fairness:
  - All req high, each requester releasing after 2 cycles.
  - Required grant order: 0, 1, 2, 3, 0, …, with no dead cycles between grants.
